// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: shared datapath widths, ALU op encodings and sequencer state encodings
package alu_muldiv_seq_pkg;
   localparam int WIDTH = 24;
   localparam int CNT_W = 5;
   localparam logic [1:0] ALU_AND = 2'b00;
   localparam logic [1:0] ALU_OR  = 2'b01;
   localparam logic [1:0] ALU_ADD = 2'b10;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/result and shared-ALU signals between decoder, ALU and the mul/div sequencer
interface alu_muldiv_seq_if;
   import alu_muldiv_seq_pkg::*;
   logic             start;
   logic             op_div;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             div_zero;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_op;
   logic             alu_a_invert;
   logic             alu_b_negate;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry_out;
   modport slave (
      input  start, op_div, op_a, op_b, alu_result, alu_carry_out,
      output busy, done, result_hi, result_lo, div_zero,
             alu_a, alu_b, alu_op, alu_a_invert, alu_b_negate
   );
   modport master (
      output start, op_div, op_a, op_b, alu_result, alu_carry_out,
      input  busy, done, result_hi, result_lo, div_zero,
             alu_a, alu_b, alu_op, alu_a_invert, alu_b_negate
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 24x24 multiply / 24/24 restoring divide, one shared-ALU add per clock; ALU_MULDIV_EARLY_TERM_EN enables MUL early termination
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
(
   input logic clk,
   input logic rst_n,
   alu_muldiv_seq_if.slave bus
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] p_hi, p_lo, m, hi_nx, lo_nx;
   logic [WIDTH:0]   s, acc;
   logic             q_bit, last, div_by_zero, early, run_mul, run_div;
   logic [2*WIDTH-1:0] p_shift;
`ifdef ALU_MULDIV_EARLY_TERM_EN
   logic [CNT_W-1:0] rem;
   assign rem     = CNT_W'(WIDTH) - cnt;
   assign early   = state == S_MUL && (p_lo & ({WIDTH{1'b1}} >> cnt)) == '0;
   assign p_shift = {p_hi, p_lo} >> rem;
`else
   assign early   = 1'b0;
   assign p_shift = '0;
`endif
   assign div_by_zero = bus.op_div && bus.op_b == '0;
   assign last        = cnt == CNT_W'(WIDTH - 1);
   assign s           = {p_hi, p_lo[WIDTH-1]};
   assign q_bit       = s[WIDTH] | bus.alu_carry_out;
   // MUL keeps the add carry so it lands in P_hi's top bit on the shift
   assign acc         = p_lo[0] ? {bus.alu_carry_out, bus.alu_result} : {1'b0, p_hi};
   assign hi_nx       = state == S_DIV ? (q_bit ? bus.alu_result : s[WIDTH-1:0]) : acc[WIDTH:1];
   assign lo_nx       = state == S_DIV ? {p_lo[WIDTH-2:0], q_bit} : {acc[0], p_lo[WIDTH-1:1]};
   assign run_mul     = state == S_MUL && !early;
   assign run_div     = state == S_DIV;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   // next state: accept start only in IDLE, finish after the last or early-terminated iteration
   always_comb begin
      state_nx = state == S_IDLE ? (bus.start ? (div_by_zero ? S_DONE : bus.op_div ? S_DIV : S_MUL) : S_IDLE)
               : state == S_DONE ? S_IDLE
               : (last || early) ? S_DONE : state;
   end
   // datapath: operand load, one shift/add iteration per cycle, result capture
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt           <= '0;
         p_hi          <= '0;
         p_lo          <= '0;
         m             <= '0;
         bus.result_hi <= '0;
         bus.result_lo <= '0;
         bus.div_zero  <= 1'b0;
      end else if (state == S_IDLE) begin
         if (bus.start) begin
            cnt          <= '0;
            p_hi         <= '0;
            p_lo         <= bus.op_div ? bus.op_a : bus.op_b;
            m            <= bus.op_div ? bus.op_b : bus.op_a;
            bus.div_zero <= div_by_zero;
            if (div_by_zero) begin
               bus.result_hi <= bus.op_a;
               bus.result_lo <= '1;
            end
         end
      end else if (state != S_DONE) begin
         cnt  <= cnt + 1'b1;
         p_hi <= hi_nx;
         p_lo <= lo_nx;
         if (early) {bus.result_hi, bus.result_lo} <= p_shift;
         else if (last) begin
            bus.result_hi <= hi_nx;
            bus.result_lo <= lo_nx;
         end
      end
   // outputs: status from state, ALU driven only while iterating, otherwise a quiet AND of zeros
   always_comb begin
      bus.busy         = state != S_IDLE;
      bus.done         = state == S_DONE;
      bus.alu_a        = run_div ? s[WIDTH-1:0] : run_mul ? p_hi : '0;
      bus.alu_b        = (run_mul || run_div) ? m : '0;
      bus.alu_op       = (run_mul || run_div) ? ALU_ADD : ALU_AND;
      bus.alu_a_invert = 1'b0;
      bus.alu_b_negate = run_div;
   end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed scoreboard bench for alu_muldiv_seq with a behavioural shared ALU
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   typedef struct {
      logic [23:0] hi;
      logic [23:0] lo;
      logic        dz;
      int          lat;
      int          lat_alt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   exp_t sb[$];

   alu_muldiv_seq_if bus();

   alu_muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // behavioural shared ALU
   logic [23:0] ea, eb;
   logic [24:0] sum;
   assign ea = bus.alu_a_invert ? ~bus.alu_a : bus.alu_a;
   assign eb = bus.alu_b_negate ? ~bus.alu_b : bus.alu_b;
   assign sum = {1'b0, ea} + {1'b0, eb} + {24'd0, bus.alu_b_negate};
   assign bus.alu_result = bus.alu_op == ALU_ADD ? sum[23:0] : bus.alu_op == ALU_OR ? (ea | eb) : (ea & eb);
   assign bus.alu_carry_out = bus.alu_op == ALU_ADD && sum[24];

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, 48'(bus.busy), 48'd0);
      check({tag, "_done"}, 48'(bus.done), 48'd0);
      check({tag, "_alu_a"}, 48'(bus.alu_a), 48'd0);
      check({tag, "_alu_b"}, 48'(bus.alu_b), 48'd0);
      check({tag, "_alu_ctl"}, 48'({bus.alu_op, bus.alu_a_invert, bus.alu_b_negate}), 48'd0);
   endtask

   task automatic run_op(input logic div, input logic [23:0] a, input logic [23:0] b, input int glitch_at);
      exp_t e;
      exp_t got;
      int   lat;
      int   bl;
      logic [47:0] prod;
      prod = 48'(a) * 48'(b);
      if (!div) begin
         e.hi = prod[47:24];
         e.lo = prod[23:0];
         e.dz = 1'b0;
`ifdef ALU_MULDIV_EARLY_TERM_EN
         bl = 0;
         for (int i = 0; i < 24; i++) if (b[i]) bl = i + 1;
         e.lat = (bl + 1 > 24) ? 24 : bl + 1;
`else
         bl = 0;
         e.lat = 24 + bl;
`endif
         e.lat_alt = e.lat;
      end else if (b == 24'd0) begin
         e.hi = a;
         e.lo = 24'hFFFFFF;
         e.dz = 1'b1;
         e.lat = 0;
         e.lat_alt = 1;
      end else begin
         e.hi = a % b;
         e.lo = a / b;
         e.dz = 1'b0;
         e.lat = 24;
         e.lat_alt = 24;
      end
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_div = div;
      bus.op_a = a;
      bus.op_b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 40) begin
         if (lat == glitch_at) begin
            bus.start = 1'b1;
            bus.op_div = 1'b1;
            bus.op_a = 24'h000001;
            bus.op_b = 24'h000000;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         lat++;
      end
      got = sb.pop_front();
      if (!bus.done) begin
         compared++;
         mismatched++;
         $error("FAIL timeout: observed no done after %0d cycles expected done", lat);
      end else begin
         compared++;
         assert (lat == got.lat || lat == got.lat_alt) else begin
            mismatched++;
            $error("FAIL latency: observed %0d expected %0d", lat, got.lat);
         end
         check("result_hi", 48'(bus.result_hi), 48'(got.hi));
         check("result_lo", 48'(bus.result_lo), 48'(got.lo));
         check("div_zero", 48'(bus.div_zero), 48'(got.dz));
         check("busy_in_done", 48'(bus.busy), 48'd1);
         @(posedge clk);
         #1;
         check("done_pulse_end", 48'(bus.done), 48'd0);
         check("idle_busy", 48'(bus.busy), 48'd0);
         check("hold_lo", 48'(bus.result_lo), 48'(got.lo));
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op_div = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      #12;
      check_quiet("reset");
      check("reset_hi", 48'(bus.result_hi), 48'd0);
      check("reset_lo", 48'(bus.result_lo), 48'd0);
      check("reset_dz", 48'(bus.div_zero), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 24'd3, 24'd5, -1);
      run_op(1'b0, 24'hFFFFFF, 24'hFFFFFF, -1);
      run_op(1'b0, 24'h123456, 24'd2, -1);
      run_op(1'b0, 24'h123456, 24'd0, -1);
      run_op(1'b1, 24'd100, 24'd7, -1);
      run_op(1'b1, 24'hFFFFFF, 24'd1, -1);
      run_op(1'b1, 24'h00ABCD, 24'd0, -1);
      run_op(1'b1, 24'd5, 24'd9, -1);
      check_quiet("idle");
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, 24'($urandom), 24'($urandom), -1);
         run_op(1'b1, 24'($urandom), 24'($urandom_range(1, 24'hFFFF)), -1);
      end
      run_op(1'b0, 24'h0ABCDE, 24'h876543, 5);
      run_op(1'b1, 24'h0ABCDE, 24'h000123, 3);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_div = 1'b0;
      bus.op_a = 24'hFFFFFF;
      bus.op_b = 24'hFFFFFF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("pre_reset_busy", 48'(bus.busy), 48'd1);
      check("pre_reset_op", 48'(bus.alu_op), 48'(ALU_ADD));
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("async_reset");
      check("async_reset_hi", 48'(bus.result_hi), 48'd0);
      check("async_reset_lo", 48'(bus.result_lo), 48'd0);
      check("async_reset_dz", 48'(bus.div_zero), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 24'd7, 24'd6, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
